// File: rtl/axi_read_arbiter_pkg.sv
// Shared constants and types for the two-port AXI read arbiter.
package axi_read_arbiter_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module axi_read_arbiter_rr_pick2
    import axi_read_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       pick_c,
    output logic       any_c
);

    always_comb begin
        any_c  = |req;
        pick_c = PORT_FETCH;
        if (req == 2'b11) begin
            pick_c = ~last_grant;
        end else if (req[PORT_LOAD]) begin
            pick_c = PORT_LOAD;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master between instruction fetch (port 0) and the load unit (port 1),
// one single-beat transaction in flight, arid tagged with the owning port.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arcache,
    output logic              m_arlock,
    output logic [2:0]        m_arprot,
    output logic [3:0]        m_arqos,
    output logic              m_arvalid,
    input  logic              m_arready,

    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic [ID_W-1:0]   m_rid,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              busy,
    output logic              err_id,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic             grant;
    logic             last_grant;
    logic [CNT_W-1:0] tmo_cnt;

    logic             pick_c;
    logic             any_c;
    logic             in_data_c;
    logic             beat_c;

    axi_read_arbiter_rr_pick2 u_pick (
        .req        ({s1_arvalid, s0_arvalid}),
        .last_grant (last_grant),
        .pick_c     (pick_c),
        .any_c      (any_c)
    );

    assign m_arid    = {3'b000, grant};
    assign m_arlen   = 8'd0;
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;
    assign m_arcache = AXI_CACHE_MOD;
    assign m_arlock  = 1'b0;
    assign m_arprot  = 3'b000;
    assign m_arqos   = 4'b0000;

    // R channel is a zero-latency pass-through steered by the current grant.
    assign in_data_c = (state == ST_DATA);
    assign m_rready  = in_data_c && ((grant == PORT_LOAD) ? s1_rready : s0_rready);
    assign beat_c    = m_rvalid && m_rready;
    assign s0_rvalid = in_data_c && (grant == PORT_FETCH) && m_rvalid;
    assign s1_rvalid = in_data_c && (grant == PORT_LOAD) && m_rvalid;
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= PORT_FETCH;
            last_grant  <= PORT_LOAD;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            s0_arready  <= 1'b0;
            s1_arready  <= 1'b0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            err_id      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            s0_arready <= 1'b0;
            s1_arready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        grant      <= pick_c;
                        m_araddr   <= (pick_c == PORT_LOAD) ? s1_araddr : s0_araddr;
                        s0_arready <= (pick_c == PORT_FETCH);
                        s1_arready <= (pick_c == PORT_LOAD);
                        m_arvalid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid  <= 1'b0;
                        last_grant <= grant;
                        tmo_cnt    <= '0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Saturating watchdog; flags a stuck memory but never forces an exit.
                    if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                    if (beat_c && (m_rid != m_arid)) begin
                        err_id <= 1'b1;
                    end
                    if (beat_c && m_rlast) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: expected grants/addresses/data are queued at request time
// and popped when the memory side sees the address handshake.
module tb_axi_read_arbiter;

    typedef struct {
        logic        port;
        logic [19:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [19:0] s0_araddr, s1_araddr;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [19:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [3:0]  m_arcache;
    logic        m_arlock;
    logic [2:0]  m_arprot;
    logic [3:0]  m_arqos;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [3:0]  m_rid;
    logic        m_rlast, m_rvalid, m_rready;
    logic        busy, err_id, err_timeout;

    int   n_err = 0;
    int   n_checks = 0;
    int   last_lat = 0;
    bit   hold [2];
    exp_t sb [$];

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arlock(m_arlock), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .err_id(err_id), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic p, input logic [19:0] addr, input logic v);
        if (p) begin
            s1_araddr  = addr;
            s1_arvalid = v;
        end else begin
            s0_araddr  = addr;
            s0_arvalid = v;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Wait for the address phase, score it against the queue, hold arready low for delay cycles.
    task automatic addr_phase(input int delay, output exp_t e);
        bit seen = 1'b0;
        int lat  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (m_arvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check("arvalid_seen", 64'(seen), 64'd1);
        if (!seen || sb.size() == 0) begin
            $fatal(1, "FAIL addr_phase: no address phase or empty scoreboard");
        end
        last_lat = lat;
        e = sb.pop_front();
        check("m_araddr", 64'(m_araddr), 64'(e.addr));
        check("m_arid", 64'(m_arid), 64'({3'b000, e.port}));
        check("own_arready", 64'(e.port ? s1_arready : s0_arready), 64'd1);
        check("other_arready", 64'(e.port ? s0_arready : s1_arready), 64'd0);
        if (!hold[e.port]) set_req(e.port, e.addr, 1'b0);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("arvalid_hold", 64'(m_arvalid), 64'd1);
            check("araddr_hold", 64'(m_araddr), 64'(e.addr));
            check("arready_pulse", 64'(e.port ? s1_arready : s0_arready), 64'd0);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        check("arvalid_drop", 64'(m_arvalid), 64'd0);
        check("busy_data", 64'(busy), 64'd1);
    endtask

    task automatic r_beat(input exp_t e, input logic [3:0] rid);
        m_rdata  = e.data;
        m_rresp  = 2'b00;
        m_rid    = rid;
        m_rlast  = 1'b1;
        m_rvalid = 1'b1;
        #1;
        check("own_rvalid", 64'(e.port ? s1_rvalid : s0_rvalid), 64'd1);
        check("other_rvalid", 64'(e.port ? s0_rvalid : s1_rvalid), 64'd0);
        check("own_rdata", 64'(e.port ? s1_rdata : s0_rdata), 64'(e.data));
        check("m_rready", 64'(m_rready), 64'd1);
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("busy_idle", 64'(busy), 64'd0);
        check("rready_idle", 64'(m_rready), 64'd0);
    endtask

    initial begin
        exp_t e;
        s0_araddr = '0; s1_araddr = '0;
        s0_rready = 1'b1; s1_rready = 1'b1;
        m_rdata = '0; m_rresp = '0; m_rid = '0;
        reset_dut();

        // Reset state and constant AR fields
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_araddr", 64'(m_araddr), 64'd0);
        check("rst_arid", 64'(m_arid), 64'd0);
        check("rst_s0_arready", 64'(s0_arready), 64'd0);
        check("rst_errs", 64'({err_id, err_timeout}), 64'd0);
        check("ar_const", 64'({m_arlen, m_arsize, m_arburst, m_arcache, m_arlock, m_arprot, m_arqos}),
              64'({8'd0, 3'b010, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0}));

        // Single fetch request
        set_req(1'b0, 20'h00010, 1'b1);
        sb.push_back('{1'b0, 20'h00010, 32'hDEADBEEF});
        addr_phase(0, e);
        check("first_latency", 64'(last_lat), 64'd1);
        r_beat(e, 4'd0);

        // Simultaneous requests after reset: fetch first, then load
        reset_dut();
        set_req(1'b0, 20'h00100, 1'b1);
        set_req(1'b1, 20'h00200, 1'b1);
        sb.push_back('{1'b0, 20'h00100, 32'h11110000});
        sb.push_back('{1'b1, 20'h00200, 32'h22220000});
        for (int k = 0; k < 2; k++) begin
            addr_phase(0, e);
            r_beat(e, {3'b000, e.port});
        end

        // Continuous contention: grants alternate 0,1,0,1,0,1
        hold[0] = 1'b1; hold[1] = 1'b1;
        set_req(1'b0, 20'h0A000, 1'b1);
        set_req(1'b1, 20'h0B000, 1'b1);
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{logic'(k % 2), (k % 2 == 1) ? 20'h0B000 : 20'h0A000, 32'hC0DE0000 + 32'(k)});
        end
        for (int k = 0; k < 6; k++) begin
            addr_phase(0, e);
            r_beat(e, {3'b000, e.port});
        end
        hold[0] = 1'b0; hold[1] = 1'b0;
        set_req(1'b0, 20'h0A000, 1'b0);
        set_req(1'b1, 20'h0B000, 1'b0);

        // Memory stalls arready for 5 cycles
        set_req(1'b1, 20'h0ABCD, 1'b1);
        sb.push_back('{1'b1, 20'h0ABCD, 32'h5A5A5A5A});
        addr_phase(5, e);
        r_beat(e, 4'd1);

        // Wrong rid on a fetch transaction is flagged but still delivered
        set_req(1'b0, 20'h00444, 1'b1);
        sb.push_back('{1'b0, 20'h00444, 32'h0BADF00D});
        addr_phase(0, e);
        r_beat(e, 4'd1);
        check("err_id_set", 64'(err_id), 64'd1);

        // Memory never answers: watchdog flags after TIMEOUT, FSM stays in DATA
        set_req(1'b1, 20'h00555, 1'b1);
        sb.push_back('{1'b1, 20'h00555, 32'h0});
        addr_phase(0, e);
        for (int i = 0; i < 250; i++) tick();
        check("tmo_early", 64'(err_timeout), 64'd0);
        for (int i = 0; i < 50; i++) tick();
        check("tmo_set", 64'(err_timeout), 64'd1);
        check("err_id_sticky", 64'(err_id), 64'd1);
        check("busy_stuck", 64'(busy), 64'd1);

        // Reset mid-transaction abandons it and clears errors
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rready", 64'(m_rready), 64'd0);
        check("mid_rst_arvalid", 64'(m_arvalid), 64'd0);
        check("mid_rst_errs", 64'({err_id, err_timeout}), 64'd0);
        rst = 1'b0;
        tick();

        // Fresh tie after that reset goes to fetch again
        set_req(1'b0, 20'h00700, 1'b1);
        set_req(1'b1, 20'h00800, 1'b1);
        sb.push_back('{1'b0, 20'h00700, 32'h77777777});
        sb.push_back('{1'b1, 20'h00800, 32'h88888888});
        for (int k = 0; k < 2; k++) begin
            addr_phase(0, e);
            r_beat(e, {3'b000, e.port});
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
